// File: rtl/bus_fabric_pkg.sv
// Shared types for the N-master / N-slave bus fabric.
// State encoding, select-width helper and split record.
package bus_fabric_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_ADDR,
    S_XFER
  } state_e;

  typedef struct packed {
    logic       valid;
    logic [2:0] mst;
    logic [2:0] slv;
  } split_rec_t;

  function automatic int sel_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_fabric_rr_arb.sv
// Round-robin arbiter; a non-empty prio mask restricts the
// search to prioritised requesters.
module bus_fabric_rr_arb #(
  parameter int N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         prio,
  input  logic [$clog2(N)-1:0] last,
  output logic [$clog2(N)-1:0] idx,
  output logic                 vld
);
  localparam int IW = $clog2(N);

  logic [N-1:0]  eff;
  logic [IW-1:0] j;

  always_comb begin
    eff = (|(req & prio)) ? (req & prio) : req;
    idx = '0;
    vld = 1'b0;
    j   = '0;
    for (int k = 1; k <= N; k++) begin
      j = IW'((int'(last) + k) % N);
      if (!vld && eff[j]) begin
        vld = 1'b1;
        idx = j;
      end
    end
  end

endmodule

// File: rtl/bus_fabric_n.sv
// N-master / N-slave bus fabric with serial slave addressing.
// Define BUS_FABRIC_SPLIT_EN to enable split transfers and resume.
module bus_fabric_n
  import bus_fabric_pkg::*;
#(
  parameter int N_M = 2,
  parameter int N_S = 3
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [N_M-1:0] B_REQ,
  input  logic [N_M-1:0] B_UTILM,
  input  logic [N_M-1:0] A_ADDM,
  input  logic [N_M-1:0] B_BUS_OUTM,
  input  logic [N_M-1:0] B_RWM,
  input  logic [N_M-1:0] B_DONEM,
  output logic [N_M-1:0] B_GRANT,
  output logic [N_M-1:0] B_SPLIT,
  output logic [N_M-1:0] B_SPL_RESUME,
  output logic [N_M-1:0] B_ERRM,
  output logic [N_M-1:0] B_BUS_INM,
  output logic [N_M-1:0] B_READYM,
  output logic [N_M-1:0] B_ACKM,
  input  logic [N_S-1:0] B_SBSY,
  input  logic [N_S-1:0] B_BUS_INS,
  input  logic [N_S-1:0] B_READYS,
  input  logic [N_S-1:0] B_ACKS,
  output logic [N_S-1:0] AD_SEL,
  output logic [N_S-1:0] B_BUS_OUTS,
  output logic [N_S-1:0] B_RWS
);
  localparam int SW = sel_w(N_S);
  localparam int MW = $clog2(N_M);
  localparam logic [SW:0] CNT_LAST = (SW+1)'(SW - 1);

  state_e         state_q, state_d;
  logic [N_M-1:0] grant_q, grant_d;
  logic [MW-1:0]  gidx_q, gidx_d;
  logic [MW-1:0]  last_q, last_d;
  logic [N_S-1:0] sel_q, sel_d;
  logic [SW-1:0]  sidx_q, sidx_d;
  logic [SW-1:0]  addr_q, addr_d, addr_nx;
  logic [SW:0]    cnt_q, cnt_d;
  logic [N_M-1:0] err_q, err_d;
  logic [N_M-1:0] prio;
  logic [MW-1:0]  arb_idx;
  logic           arb_vld;

`ifdef BUS_FABRIC_SPLIT_EN
  logic [N_M-1:0] split_q, split_d;
  logic [N_M-1:0] resume_q, resume_d;
  logic [N_M-1:0] pend_q, pend_d;
  split_rec_t     rec_q, rec_d;
  logic           rec_busy;

  assign prio         = pend_q;
  assign B_SPLIT      = split_q;
  assign B_SPL_RESUME = resume_q;
`else
  logic unused_sbsy;

  assign unused_sbsy  = ^B_SBSY;
  assign prio         = '0;
  assign B_SPLIT      = '0;
  assign B_SPL_RESUME = '0;
`endif

  bus_fabric_rr_arb #(.N(N_M)) u_arb (
    .req  (B_REQ),
    .prio (prio),
    .last (last_q),
    .idx  (arb_idx),
    .vld  (arb_vld)
  );

  assign addr_nx = SW'({addr_q, A_ADDM[gidx_q]});

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    last_d  = last_q;
    sel_d   = sel_q;
    sidx_d  = sidx_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    err_d   = '0;
`ifdef BUS_FABRIC_SPLIT_EN
    split_d  = '0;
    resume_d = '0;
    pend_d   = pend_q;
    rec_d    = rec_q;
    rec_busy = 1'b0;
    for (int s = 0; s < N_S; s++)
      if (rec_q.slv == 3'(s)) rec_busy = B_SBSY[s];
    // The parked slave went idle: wake its master.
    if (rec_q.valid && !rec_busy) begin
      for (int m = 0; m < N_M; m++)
        if (rec_q.mst == 3'(m)) begin
          resume_d[m] = 1'b1;
          pend_d[m]   = 1'b1;
        end
      rec_d = '0;
    end
`endif
    unique case (state_q)
      S_IDLE: begin
        cnt_d  = '0;
        addr_d = '0;
        if (arb_vld) begin
          grant_d          = '0;
          grant_d[arb_idx] = 1'b1;
          gidx_d           = arb_idx;
          last_d           = arb_idx;
          state_d          = S_GRANT;
`ifdef BUS_FABRIC_SPLIT_EN
          pend_d[arb_idx]  = 1'b0;
`endif
        end
      end
      S_GRANT, S_ADDR: begin
        if (B_UTILM[gidx_q]) begin
          addr_d  = addr_nx;
          cnt_d   = cnt_q + 1'b1;
          state_d = S_ADDR;
          if (cnt_q == CNT_LAST) begin
            if (int'(addr_nx) < N_S) begin
              sel_d          = '0;
              sel_d[addr_nx] = 1'b1;
              sidx_d         = addr_nx;
              state_d        = S_XFER;
            end else begin
              err_d[gidx_q] = 1'b1;
              grant_d       = '0;
              state_d       = S_IDLE;
            end
          end
        end
      end
      S_XFER: begin
        if (B_DONEM[gidx_q]) begin
          grant_d = '0;
          sel_d   = '0;
          state_d = S_IDLE;
        end
`ifdef BUS_FABRIC_SPLIT_EN
        else if (B_SBSY[sidx_q]) begin
          if (rec_q.valid) begin
            err_d[gidx_q] = 1'b1;
          end else begin
            split_d[gidx_q] = 1'b1;
            rec_d = '{valid: 1'b1,
                      mst: 3'(gidx_q),
                      slv: 3'(sidx_q)};
          end
          grant_d = '0;
          sel_d   = '0;
          state_d = S_IDLE;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      gidx_q   <= '0;
      last_q   <= MW'(N_M - 1);
      sel_q    <= '0;
      sidx_q   <= '0;
      addr_q   <= '0;
      cnt_q    <= '0;
      err_q    <= '0;
`ifdef BUS_FABRIC_SPLIT_EN
      split_q  <= '0;
      resume_q <= '0;
      pend_q   <= '0;
      rec_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      gidx_q   <= gidx_d;
      last_q   <= last_d;
      sel_q    <= sel_d;
      sidx_q   <= sidx_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
`ifdef BUS_FABRIC_SPLIT_EN
      split_q  <= split_d;
      resume_q <= resume_d;
      pend_q   <= pend_d;
      rec_q    <= rec_d;
`endif
    end
  end

  assign B_GRANT = grant_q;
  assign AD_SEL  = sel_q;
  assign B_ERRM  = err_q;

  // sel_q is only non-zero while a grant is held.
  assign B_BUS_OUTS = sel_q & {N_S{B_BUS_OUTM[gidx_q]}};
  assign B_RWS      = sel_q & {N_S{B_RWM[gidx_q]}};
  assign B_BUS_INM  = grant_q & {N_M{|(sel_q & B_BUS_INS)}};
  assign B_READYM   = grant_q & {N_M{|(sel_q & B_READYS)}};
  assign B_ACKM     = grant_q & {N_M{|(sel_q & B_ACKS)}};

endmodule

// File: tb/tb_bus_fabric_n.sv
// Scoreboard bench for bus_fabric_n (N_M=2, N_S=3).
// Split scenario runs only when BUS_FABRIC_SPLIT_EN is defined.
module tb_bus_fabric_n;
  localparam int N_M = 2;
  localparam int N_S = 3;
  localparam int SW  = 2;

  logic           CLK = 1'b0;
  logic           RST = 1'b1;
  logic [N_M-1:0] B_REQ = '0, B_UTILM = '0, A_ADDM = '0;
  logic [N_M-1:0] B_BUS_OUTM = '0, B_RWM = '0, B_DONEM = '0;
  logic [N_M-1:0] B_GRANT, B_SPLIT, B_SPL_RESUME, B_ERRM;
  logic [N_M-1:0] B_BUS_INM, B_READYM, B_ACKM;
  logic [N_S-1:0] B_SBSY = '0, B_BUS_INS = '0;
  logic [N_S-1:0] B_READYS = '0, B_ACKS = '0;
  logic [N_S-1:0] AD_SEL, B_BUS_OUTS, B_RWS;

  int checks = 0;
  int failures = 0;
  int bitpos = 0;
  int xcnt = 0;
  int done_at = 4;
  logic [SW-1:0] m_addr [N_M];
  int exp_q [$];

  bus_fabric_n #(.N_M(N_M), .N_S(N_S)) dut (
    .CLK(CLK), .RST(RST),
    .B_REQ(B_REQ), .B_UTILM(B_UTILM), .A_ADDM(A_ADDM),
    .B_BUS_OUTM(B_BUS_OUTM), .B_RWM(B_RWM), .B_DONEM(B_DONEM),
    .B_GRANT(B_GRANT), .B_SPLIT(B_SPLIT),
    .B_SPL_RESUME(B_SPL_RESUME), .B_ERRM(B_ERRM),
    .B_BUS_INM(B_BUS_INM), .B_READYM(B_READYM), .B_ACKM(B_ACKM),
    .B_SBSY(B_SBSY), .B_BUS_INS(B_BUS_INS),
    .B_READYS(B_READYS), .B_ACKS(B_ACKS),
    .AD_SEL(AD_SEL), .B_BUS_OUTS(B_BUS_OUTS), .B_RWS(B_RWS)
  );

  always #5 CLK = ~CLK;

  function automatic int oh_idx(input logic [N_M-1:0] v);
    int r = 0;
    for (int i = 0; i < N_M; i++) if (v[i]) r = i;
    return r;
  endfunction

  // Advance one clock, then play the granted master's role.
  task automatic drive_cycle();
    int g;
    @(posedge CLK); #1;
    if (B_GRANT == '0) begin
      B_UTILM = '0; A_ADDM = '0; B_DONEM = '0;
      bitpos = 0; xcnt = 0;
    end else begin
      g = oh_idx(B_GRANT);
      if (AD_SEL == '0) begin
        B_UTILM = '0; B_UTILM[g] = 1'b1; A_ADDM = '0;
        if (bitpos < SW) A_ADDM[g] = m_addr[g][SW-1-bitpos];
        bitpos++;
      end else begin
        B_UTILM = '0; B_DONEM = '0;
        xcnt++;
        if (xcnt >= done_at) B_DONEM[g] = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) drive_cycle();
    checks++; if (B_GRANT !== '0) begin failures++;
      $display("FAIL reset_grant got=%b exp=00", B_GRANT); end
    checks++; if (AD_SEL !== '0) begin failures++;
      $display("FAIL reset_sel got=%b exp=000", AD_SEL); end
    checks++; if (B_ERRM !== '0) begin failures++;
      $display("FAIL reset_err got=%b exp=00", B_ERRM); end
    checks++; if (B_SPLIT !== '0) begin failures++;
      $display("FAIL reset_split got=%b exp=00", B_SPLIT); end
    checks++; if (B_SPL_RESUME !== '0) begin failures++;
      $display("FAIL reset_resume got=%b exp=00", B_SPL_RESUME); end
    RST = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [N_M-1:0] prev;
    int e, gap, seen;
    exp_q = {};
    exp_q.push_back(0); exp_q.push_back(1);
    exp_q.push_back(0); exp_q.push_back(1);
    m_addr[0] = 2'b00; m_addr[1] = 2'b00;
    done_at = 4; B_REQ = 2'b11;
    prev = B_GRANT; gap = 0; seen = 0;
    for (int c = 0; c < 80 && exp_q.size() > 0; c++) begin
      drive_cycle();
      if (B_GRANT != '0 && prev == '0) begin
        e = exp_q.pop_front();
        checks++; if (B_GRANT !== N_M'(1 << e)) begin failures++;
          $display("FAIL rr_grant got=%b exp_master=%0d", B_GRANT, e); end
        if (seen > 0) begin
          checks++; if (gap !== 1) begin failures++;
            $display("FAIL rr_gap got=%0d exp=1", gap); end
        end
        seen++; gap = 0;
      end else if (B_GRANT == '0) gap++;
      prev = B_GRANT;
    end
    checks++; if (exp_q.size() != 0) begin failures++;
      $display("FAIL rr_timeout pending=%0d exp=0", exp_q.size()); end
    B_REQ = '0;
    repeat (12) drive_cycle();
  endtask

  task automatic test_decode();
    logic [N_M-1:0] prev;
    int e, k, got, held;
    exp_q = {}; exp_q.push_back(3'b100);
    m_addr[1] = 2'b10; done_at = 5; B_REQ = 2'b10;
    prev = B_GRANT; k = -1; got = 0; held = 0;
    for (int c = 0; c < 40; c++) begin
      drive_cycle();
      if (B_GRANT != '0 && prev == '0) k = 0;
      else if (k >= 0) k++;
      if (AD_SEL != '0 && got == 0) begin
        got = 1; B_REQ = '0;
        e = exp_q.pop_front();
        checks++; if (AD_SEL !== N_S'(e)) begin failures++;
          $display("FAIL dec_sel got=%b exp=%b", AD_SEL, N_S'(e)); end
        checks++; if (k !== 2) begin failures++;
          $display("FAIL dec_latency got=%0d exp=2", k); end
        B_BUS_OUTM = 2'b10; #1;
        checks++; if (B_BUS_OUTS !== 3'b100) begin failures++;
          $display("FAIL dec_wdata1 got=%b exp=100", B_BUS_OUTS); end
        B_BUS_OUTM = 2'b01; #1;
        checks++; if (B_BUS_OUTS !== 3'b000) begin failures++;
          $display("FAIL dec_wdata0 got=%b exp=000", B_BUS_OUTS); end
        B_RWM = 2'b10; #1;
        checks++; if (B_RWS !== 3'b100) begin failures++;
          $display("FAIL dec_rw got=%b exp=100", B_RWS); end
        B_BUS_INS = 3'b100; B_READYS = 3'b100; B_ACKS = 3'b100; #1;
        checks++;
        if ({B_BUS_INM, B_READYM, B_ACKM} !== 6'b101010) begin
          failures++;
          $display("FAIL dec_rdata got=%b%b%b exp=101010",
                   B_BUS_INM, B_READYM, B_ACKM);
        end
        B_BUS_INS = 3'b011; B_READYS = 3'b011; #1;
        checks++; if ({B_BUS_INM, B_READYM} !== 4'b0000) begin
          failures++;
          $display("FAIL dec_rgate got=%b%b exp=0000",
                   B_BUS_INM, B_READYM);
        end
        B_BUS_OUTM = '0; B_RWM = '0;
        B_BUS_INS = '0; B_READYS = '0; B_ACKS = '0;
      end
      if (AD_SEL != '0 && xcnt == 3 && held == 0) begin
        held = 1;
        checks++; if (B_GRANT !== 2'b10) begin failures++;
          $display("FAIL dec_util_low got=%b exp=10", B_GRANT); end
      end
      prev = B_GRANT;
      if (got != 0 && B_GRANT == '0) break;
    end
    checks++; if (got !== 1) begin failures++;
      $display("FAIL dec_timeout got=%0d exp=1", got); end
    repeat (3) drive_cycle();
  endtask

  task automatic test_addr_error();
    logic [N_M-1:0] prev;
    int e, k, errs, sel_seen;
    exp_q = {}; exp_q.push_back(1);
    m_addr[0] = 2'b11; done_at = 4; B_REQ = 2'b01;
    prev = B_GRANT; k = -1; errs = 0; sel_seen = 0;
    for (int c = 0; c < 30; c++) begin
      drive_cycle();
      if (B_GRANT != '0 && prev == '0) k = 0;
      else if (k >= 0) k++;
      if (AD_SEL != '0) sel_seen = 1;
      if (B_ERRM != '0) begin
        errs++;
        if (errs == 1) begin
          B_REQ = '0;
          e = exp_q.pop_front();
          checks++; if (B_ERRM !== N_M'(e)) begin failures++;
            $display("FAIL err_pulse got=%b exp=%b", B_ERRM, N_M'(e)); end
          checks++; if (k !== 2) begin failures++;
            $display("FAIL err_latency got=%0d exp=2", k); end
          checks++; if (B_GRANT !== '0) begin failures++;
            $display("FAIL err_drop got=%b exp=00", B_GRANT); end
        end
      end
      prev = B_GRANT;
    end
    checks++; if (errs !== 1) begin failures++;
      $display("FAIL err_width got=%0d exp=1", errs); end
    checks++; if (sel_seen !== 0) begin failures++;
      $display("FAIL err_sel got=%0d exp=0", sel_seen); end
  endtask

  task automatic test_reset_mid();
    logic [N_M-1:0] prev;
    int hit, e;
    m_addr[0] = 2'b00; m_addr[1] = 2'b00;
    done_at = 50; B_REQ = 2'b10; hit = 0;
    for (int c = 0; c < 20; c++) begin
      drive_cycle();
      if (AD_SEL != '0 && xcnt == 2) begin
        hit = 1;
        B_BUS_OUTM = '1; B_RWM = '1; B_BUS_INS = '1;
        B_READYS = '1; B_ACKS = '1; B_REQ = 2'b11;
        RST = 1'b1;
        break;
      end
    end
    checks++; if (hit !== 1) begin failures++;
      $display("FAIL rst_mid_timeout got=%0d exp=1", hit); end
    drive_cycle();
    RST = 1'b0;
    checks++;
    if ({B_GRANT, AD_SEL, B_ERRM, B_SPLIT, B_SPL_RESUME} !== '0) begin
      failures++;
      $display("FAIL rst_mid_ctrl got=%b_%b_%b_%b_%b exp=0",
               B_GRANT, AD_SEL, B_ERRM, B_SPLIT, B_SPL_RESUME);
    end
    checks++;
    if ({B_BUS_OUTS, B_RWS, B_BUS_INM, B_READYM, B_ACKM} !== '0) begin
      failures++;
      $display("FAIL rst_mid_data got=%b_%b_%b_%b_%b exp=0",
               B_BUS_OUTS, B_RWS, B_BUS_INM, B_READYM, B_ACKM);
    end
    B_BUS_OUTM = '0; B_RWM = '0; B_BUS_INS = '0;
    B_READYS = '0; B_ACKS = '0; done_at = 3;
    exp_q = {}; exp_q.push_back(0);
    prev = B_GRANT;
    for (int c = 0; c < 10 && exp_q.size() > 0; c++) begin
      drive_cycle();
      if (B_GRANT != '0 && prev == '0) begin
        e = exp_q.pop_front();
        checks++; if (B_GRANT !== N_M'(1 << e)) begin failures++;
          $display("FAIL rst_mid_next got=%b exp_master=%0d", B_GRANT, e); end
        B_REQ = '0;
      end
      prev = B_GRANT;
    end
    checks++; if (exp_q.size() != 0) begin failures++;
      $display("FAIL rst_mid_regrant pending=%0d exp=0", exp_q.size()); end
    B_REQ = '0;
    repeat (10) drive_cycle();
  endtask

`ifdef BUS_FABRIC_SPLIT_EN
  task automatic test_split();
    logic [N_M-1:0] prev;
    int e, busy;
    RST = 1'b1; drive_cycle(); RST = 1'b0;
    m_addr[0] = 2'b01; m_addr[1] = 2'b00;
    done_at = 4; B_REQ = 2'b11; busy = -1;
    exp_q = {};
    exp_q.push_back(8'h00); exp_q.push_back(8'h10);
    exp_q.push_back(8'h01); exp_q.push_back(8'h20);
    exp_q.push_back(8'h00);
    prev = B_GRANT;
    for (int c = 0; c < 100 && exp_q.size() > 0; c++) begin
      drive_cycle();
      if (B_GRANT != '0 && prev == '0) begin
        e = exp_q.pop_front();
        checks++; if (oh_idx(B_GRANT) !== e) begin failures++;
          $display("FAIL split_seq got=grant%0d exp=%h",
                   oh_idx(B_GRANT), e); end
        if (B_GRANT == 2'b10) B_REQ[1] = 1'b0;
      end
      if (B_SPLIT != '0) begin
        e = exp_q.pop_front();
        checks++; if (8'h10 + oh_idx(B_SPLIT) !== e) begin failures++;
          $display("FAIL split_seq got=split%b exp=%h", B_SPLIT, e); end
        checks++; if ({B_GRANT, AD_SEL} !== '0) begin failures++;
          $display("FAIL split_drop got=%b_%b exp=0", B_GRANT, AD_SEL); end
        B_REQ[0] = 1'b0;
      end
      if (B_SPL_RESUME != '0) begin
        e = exp_q.pop_front();
        checks++; if (8'h20 + oh_idx(B_SPL_RESUME) !== e) begin failures++;
          $display("FAIL split_seq got=resume%b exp=%h", B_SPL_RESUME, e);
        end
        B_REQ = 2'b11;
      end
      if (busy == -1 && B_GRANT == 2'b01 && AD_SEL != '0) begin
        B_SBSY = 3'b010; busy = 0;
      end else if (busy >= 0) begin
        busy++;
        if (busy == 10) begin B_SBSY = '0; busy = -2; end
      end
      prev = B_GRANT;
    end
    checks++; if (exp_q.size() != 0) begin failures++;
      $display("FAIL split_timeout pending=%0d exp=0", exp_q.size()); end
    B_REQ = '0; B_SBSY = '0;
    repeat (15) drive_cycle();
  endtask
`else
  task automatic test_split_disabled();
    int spl, xmax, errs;
    m_addr[0] = 2'b01; done_at = 4; B_REQ = 2'b01;
    spl = 0; xmax = 0; errs = 0;
    for (int c = 0; c < 30; c++) begin
      drive_cycle();
      if (B_GRANT != '0) B_REQ = '0;
      if (AD_SEL != '0) B_SBSY = 3'b010;
      if (xcnt > xmax) xmax = xcnt;
      if (B_SPLIT != '0 || B_SPL_RESUME != '0) spl++;
      if (B_ERRM != '0) errs++;
    end
    checks++; if (spl !== 0) begin failures++;
      $display("FAIL nosplit_pulse got=%0d exp=0", spl); end
    checks++; if (xmax !== 4) begin failures++;
      $display("FAIL nosplit_xfer got=%0d exp=4", xmax); end
    checks++; if (errs !== 0) begin failures++;
      $display("FAIL nosplit_err got=%0d exp=0", errs); end
    B_SBSY = '0;
    repeat (3) drive_cycle();
  endtask
`endif

  initial begin
    m_addr[0] = '0; m_addr[1] = '0;
    test_reset();
    test_round_robin();
    test_decode();
    test_addr_error();
    test_reset_mid();
`ifdef BUS_FABRIC_SPLIT_EN
    test_split();
`else
    test_split_disabled();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_fabric_n.md
BUS_FABRIC_N -- requirements
Module: bus_fabric_n

Interface
REQ-001 Parameter N_M, default 2, number of masters (2..8).
REQ-002 Parameter N_S, default 3, number of slaves (2..8); SEL_W = $clog2(N_S), minimum 1, derived in the package function.
REQ-003 CLK  in  1  single clock, all state on rising edge.
REQ-004 RST  in  1  reset; one clock; reset is synchronous and active-high.
REQ-005 B_REQ, B_UTILM, A_ADDM, B_BUS_OUTM, B_RWM, B_DONEM  in  N_M each  master request, bus-in-use, serial slave-select address, serial write data, read/write, transfer done.
REQ-006 B_GRANT, B_SPLIT, B_SPL_RESUME, B_ERRM, B_BUS_INM, B_READYM, B_ACKM  out  N_M each  grant, split notice, resume pulse, error pulse, serial read data, ready, ack.
REQ-007 B_SBSY, B_BUS_INS, B_READYS, B_ACKS  in  N_S each  slave busy, serial read data, ready, ack.
REQ-008 AD_SEL, B_BUS_OUTS, B_RWS  out  N_S each  one-hot slave select, write data, read/write.

Function
REQ-009 FSM states IDLE, GRANT, ADDR, XFER; one-hot B_GRANT is registered and held from GRANT until return to IDLE.
REQ-010 IDLE: any B_REQ bit high -> winner latched, GRANT next cycle; no request -> stay IDLE.
REQ-011 Arbitration is round-robin: search starts at last-granted index +1 mod N_M.
REQ-012 A master with a pending resume (REQ-020) and B_REQ high wins over round-robin.
REQ-013 GRANT -> ADDR on first cycle granted B_UTILM is high; that cycle samples address bit 0 (MSB first).
REQ-014 ADDR samples A_ADDM[granted] each cycle B_UTILM is high; cycles with B_UTILM low do not count.
REQ-015 After SEL_W bits: index < N_S -> AD_SEL one-hot asserted next cycle, state XFER; index >= N_S -> one-cycle B_ERRM[granted] pulse, grant dropped, IDLE.
REQ-016 Datapath is combinational and gated: B_BUS_OUTS and B_RWS carry only granted master's bits, only on selected slave, others 0; B_BUS_INM, B_READYM, B_ACKM carry only selected slave's bits, only to granted master, others 0.
REQ-017 XFER: B_DONEM[granted] high -> AD_SEL and B_GRANT low next cycle, IDLE; minimum one idle cycle between grants.
REQ-018 Simultaneous B_DONEM and split condition: DONE wins, no split.
REQ-019 Split: in XFER, B_SBSY[selected] high with no split record -> one-cycle B_SPLIT[granted] pulse, record {master, slave}, drop grant and AD_SEL, IDLE.
REQ-020 Resume: split record valid and B_SBSY[recorded slave] low -> one-cycle B_SPL_RESUME[recorded master] pulse, record cleared, master marked resume-pending until next granted.
REQ-021 Split condition while a record is already valid -> B_ERRM[granted] pulse instead of B_SPLIT, grant dropped, IDLE.
REQ-022 B_UTILM low for the granted master in XFER does not end the transfer; only DONE, split or error do.

Reset
REQ-023 While RST high: state IDLE; B_GRANT, AD_SEL, B_SPLIT, B_SPL_RESUME, B_ERRM all 0; split record and resume-pending cleared; round-robin pointer = N_M-1, so master 0 wins first.
REQ-024 RST mid-transfer aborts with no DONE, SPLIT or ERR pulse emitted; gated datapath outputs 0 the cycle after reset asserts.

Configuration
REQ-025 Macro BUS_FABRIC_SPLIT_EN defined: REQ-019..021 active.
REQ-026 BUS_FABRIC_SPLIT_EN undefined: B_SBSY ignored, B_SPLIT and B_SPL_RESUME tied 0, no split record or resume priority.

Structure
REQ-027 Package bus_fabric_pkg holds the state enum, SEL_W function and split-record struct.
REQ-028 Sub-module bus_fabric_rr_arb (N-bit round-robin with priority override) is instantiated once.

Verification
REQ-029 Masters 0 and 1 both request continuously, each DONE after 4 XFER cycles -> grants alternate 0,1,0,1 with one idle cycle between.
REQ-030 Master 1 shifts address 2'b10 -> AD_SEL=3'b100 one cycle after 2nd bit; B_BUS_OUTM[1] mirrors on B_BUS_OUTS[2] only.
REQ-031 Master 0 shifts 2'b11 with N_S=3 -> B_ERRM[0] one-cycle pulse, B_GRANT=0 next cycle, AD_SEL never asserted.
REQ-032 Slave 1 asserts B_SBSY in XFER for master 0, drops 10 cycles later -> B_SPLIT[0] pulse, master 1 served meanwhile, B_SPL_RESUME[0] pulse, master 0 granted ahead of master 1.
REQ-033 RST for 1 cycle during XFER -> all outputs 0 next cycle; next grant goes to master 0.
